// File: rtl/xulie_pkg.sv
// Shared constants for the xulie serial pattern detector: pattern limits,
// the default pattern and the match-counter width and saturating increment.
`timescale 1ns/1ps
package xulie_pkg;

    localparam int              PAT_LEN_MAX = 16;
    localparam logic [3:0]      PAT_DEFAULT = 4'b1110;
    localparam int              CNT_W       = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/xulie_sat_cnt.sv
// Saturating event counter used for the optional match count of xulie_detect_param
// (present only when XULIE_MATCH_CNT_EN is defined).
`timescale 1ns/1ps
module xulie_sat_cnt
    import xulie_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= sat_inc(cnt);
        end
    end

endmodule

// File: rtl/xulie_detect_param.sv
// Parameterised serial pattern detector with registered (Moore) and early (Mealy)
// match flags; optional match counter enabled by macro XULIE_MATCH_CNT_EN.
`timescale 1ns/1ps
module xulie_detect_param
    import xulie_pkg::*;
#(
    parameter int                 PAT_LEN  = 4,
    parameter logic [PAT_LEN-1:0] PAT_INIT = PAT_LEN'(PAT_DEFAULT),
    parameter int                 OVERLAP  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               Din,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
    output logic               Dout,
    output logic               Dout_early
`ifdef XULIE_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0]   match_cnt
`endif
);

    localparam int FW = $clog2(PAT_LEN + 1);

    logic [PAT_LEN-1:0] pat;
    logic [PAT_LEN-1:0] hist;
    logic [FW-1:0]      fill;
    logic [PAT_LEN-1:0] hist_next;
    logic               hit;
    logic               unused_hist_msb;

    // The oldest history bit is shifted out before it is ever compared.
    assign unused_hist_msb = hist[PAT_LEN-1];

    assign hist_next  = {hist[PAT_LEN-2:0], Din};
    assign hit        = en & ~pat_load
                      & (fill >= FW'(PAT_LEN - 1))
                      & (hist_next == pat);
    assign Dout_early = hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat  <= PAT_INIT;
            hist <= '0;
            fill <= '0;
            Dout <= 1'b0;
        end else begin
            // hit is already forced low by pat_load and by en=0.
            Dout <= hit;
            if (pat_load) begin
                pat  <= pat_in;
                fill <= '0;
            end else if (en) begin
                hist <= hist_next;
                if (OVERLAP == 0 && hit) begin
                    fill <= '0;
                end else if (fill != FW'(PAT_LEN)) begin
                    fill <= fill + FW'(1);
                end
            end
        end
    end

`ifdef XULIE_MATCH_CNT_EN
    // Dout rises on this edge exactly when hit is set and Dout is still low.
    xulie_sat_cnt u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (hit & ~Dout),
        .clr   (pat_load),
        .cnt   (match_cnt)
    );
`endif

endmodule

// File: tb/tb_xulie_detect_param.sv
// Directed scoreboard bench for xulie_detect_param, run on an overlapping and a
// non-overlapping instance side by side; counter checks need XULIE_MATCH_CNT_EN.
`timescale 1ns/1ps
module tb_xulie_detect_param;

    typedef struct {
        string tag;
        logic  exp1;
        logic  exp0;
    } sb_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       din = 1'b0;
    logic       pat_load = 1'b0;
    logic [3:0] pat_in = 4'b0000;
    logic       dout1, early1, dout0, early0;
`ifdef XULIE_MATCH_CNT_EN
    logic [7:0] cnt1, cnt0;
`endif

    int  checks = 0;
    int  errors = 0;
    sb_t sb[$];

    always #5 clk = ~clk;

    xulie_detect_param #(.PAT_LEN(4), .PAT_INIT(4'b1110), .OVERLAP(1)) u1 (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .Din        (din),
        .pat_load   (pat_load),
        .pat_in     (pat_in),
        .Dout       (dout1),
        .Dout_early (early1)
`ifdef XULIE_MATCH_CNT_EN
        ,
        .match_cnt  (cnt1)
`endif
    );

    xulie_detect_param #(.PAT_LEN(4), .PAT_INIT(4'b1110), .OVERLAP(0)) u0 (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .Din        (din),
        .pat_load   (pat_load),
        .pat_in     (pat_in),
        .Dout       (dout0),
        .Dout_early (early0)
`ifdef XULIE_MATCH_CNT_EN
        ,
        .match_cnt  (cnt0)
`endif
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check the Mealy flags, queue the Moore
    // expectation, then pop and compare it just after the rising edge.
    task automatic step(input logic e, input logic d, input logic pl, input logic [3:0] pi,
                        input logic x1, input logic x0, input string tag);
        sb_t s;
        @(negedge clk);
        en = e; din = d; pat_load = pl; pat_in = pi;
        #1;
        check({tag, " early ov1"}, 16'(early1), 16'(x1));
        check({tag, " early ov0"}, 16'(early0), 16'(x0));
        sb.push_back('{tag: tag, exp1: x1, exp0: x0});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, " scoreboard empty"}, 16'd0, 16'd1);
        end else begin
            s = sb.pop_front();
            check({s.tag, " dout ov1"}, 16'(dout1), 16'(s.exp1));
            check({s.tag, " dout ov0"}, 16'(dout0), 16'(s.exp0));
        end
    endtask

    // Bits sent MSB first; m1/m0 mark the bits expected to complete a match.
    task automatic run(input logic [15:0] d, input logic [15:0] m1, input logic [15:0] m0,
                       input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, d[i], 1'b0, 4'b0000, m1[i], m0[i], $sformatf("%s b%0d", tag, n - i));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] seq;
        logic [15:0] msk;

        // Reset state, with en and Din active so only fill gates the flag.
        en = 1'b1; din = 1'b0;
        #12;
        check("rst dout ov1", 16'(dout1), 16'd0);
        check("rst early ov1", 16'(early1), 16'd0);
        check("rst pat", 16'(u1.pat), 16'hE);
        @(negedge clk);
        reset = 1'b1;

        // Default pattern 1110 on a long stream: hits on bits 9 and 13.
        seq = 16'b0101_1111_0111_0100;
        msk = 16'h0088;
        run(seq, msk, msk, 16, "stream");

        // New pattern 1010: overlap gives two matches, non-overlap one.
        step(1'b1, 1'b1, 1'b1, 4'b1010, 1'b0, 1'b0, "load 1010");
        run(16'b101010, 16'b000101, 16'b000100, 6, "pat1010");

        // Pattern 1111 on a run of ones: back-to-back matches only with overlap.
        step(1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, 1'b0, "load 1111");
        run(16'b111111, 16'b000111, 16'b000100, 6, "pat1111");

        // en=0 gap inside a pattern holds state and clears Dout.
        step(1'b1, 1'b0, 1'b1, 4'b1110, 1'b0, 1'b0, "load 1110");
        run(16'b111, 16'b000, 16'b000, 3, "gap pre");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "gap idle");
        check("gap fill held", 16'(u1.fill), 16'd3);
        step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, "gap final 0");
        step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "gap after");

        // Reset mid-pattern discards the partial match.
        run(16'b111, 16'b000, 16'b000, 3, "rst pre");
        @(negedge clk);
        reset = 1'b0; en = 1'b0;
        #1;
        check("midrst dout", 16'(dout1), 16'd0);
        check("midrst early", 16'(early1), 16'd0);
        check("midrst fill", 16'(u0.fill), 16'd0);
        @(negedge clk);
        reset = 1'b1;
        run(16'b01110, 16'b00001, 16'b00001, 5, "post rst");

        // pat_load on the final bit of 1110 wins over the match.
        run(16'b111, 16'b000, 16'b000, 3, "load race pre");
        step(1'b1, 1'b0, 1'b1, 4'b0101, 1'b0, 1'b0, "load race");
        check("race pat ov1", 16'(u1.pat), 16'h5);
        check("race fill ov1", 16'(u1.fill), 16'd0);
        check("race fill ov0", 16'(u0.fill), 16'd0);
        run(16'b0101, 16'b0001, 16'b0001, 4, "pat0101");

`ifdef XULIE_MATCH_CNT_EN
        step(1'b1, 1'b0, 1'b1, 4'b1110, 1'b0, 1'b0, "cnt load");
        check("cnt cleared", 16'(cnt1), 16'd0);
        run(16'b1110, 16'b0001, 16'b0001, 4, "cnt first");
        check("cnt one ov1", 16'(cnt1), 16'd1);
        check("cnt one ov0", 16'(cnt0), 16'd1);
        for (int k = 1; k < 300; k++) run(16'b1110, 16'b0001, 16'b0001, 4, "cnt");
        check("cnt sat ov1", 16'(cnt1), 16'd255);
        check("cnt sat ov0", 16'(cnt0), 16'd255);
        step(1'b1, 1'b0, 1'b1, 4'b1110, 1'b0, 1'b0, "cnt clr");
        check("cnt clr ov1", 16'(cnt1), 16'd0);
        check("cnt clr ov0", 16'(cnt0), 16'd0);
`endif

        check("scoreboard drained", 16'(sb.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
